// File: rtl/motor_controller.sv
// -----------------------------------------------------------------------------
// motor_controller
//
// Drives two H-bridge motors (left and right) from a line-tracker policy code.
// Each side has a target duty that depends on the policy. A working duty
// ramps toward that target in RAMP_STEP increments on every ramp tick. The
// applied duty follows the working duty only at PWM period boundaries, so a
// PWM period is never cut short or stretched. A stop request (target 0)
// bypasses the ramp and takes effect at once.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   state      : policy code (00 stop, 01 turn_right, 10 turn_left,
//                11 go_straight)
//   start_move : motion enable; low forces stop
//   left_pwm   : left motor enable PWM (registered)
//   right_pwm  : right motor enable PWM (registered)
//   left_in    : left H-bridge IN1/IN2 (10 forward, 00 coast)
//   right_in   : right H-bridge IN1/IN2 (10 forward, 00 coast)
//   moving     : high while either applied duty is nonzero (registered)
// -----------------------------------------------------------------------------
module motor_controller #(
    parameter int PWM_BITS  = 10,
    parameter int FAST_DUTY = 1000,
    parameter int SLOW_DUTY = 300,
    parameter int RAMP_STEP = 8,
    parameter int RAMP_DIV  = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    input  logic       start_move,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_in,
    output logic [1:0] right_in,
    output logic       moving
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [PWM_BITS-1:0] FAST_D   = PWM_BITS'(FAST_DUTY);
    localparam logic [PWM_BITS-1:0] SLOW_D   = PWM_BITS'(SLOW_DUTY);
    localparam logic [PWM_BITS-1:0] STEP_D   = PWM_BITS'(RAMP_STEP);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(RAMP_DIV - 1);

    // Registered copies of the inputs; every decision uses these.
    logic [1:0]          state_reg;
    logic                start_reg;

    logic [PWM_BITS-1:0] cnt_reg;
    logic [DIV_W-1:0]    div_reg;
    logic                cnt_wrap;
    logic                ramp_tick;

    // Index 0 is the left side, index 1 the right side.
    logic [1:0][PWM_BITS-1:0] target;
    logic [1:0]               pwm_vec;
    logic [1:0]               applied_nz;
    logic                     moving_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= 2'b00;
            start_reg  <= 1'b0;
            cnt_reg    <= '0;
            div_reg    <= '0;
            moving_reg <= 1'b0;
        end else begin
            state_reg  <= state;
            start_reg  <= start_move;
            cnt_reg    <= cnt_reg + 1'b1;
            div_reg    <= ramp_tick ? '0 : div_reg + 1'b1;
            moving_reg <= |applied_nz;
        end
    end

    // The counter is at all-ones on the clock where it wraps to 0.
    assign cnt_wrap  = (cnt_reg == '1);
    assign ramp_tick = (div_reg == DIV_LAST);

    always_comb begin
        target[0] = '0;
        target[1] = '0;
        if (start_reg) begin
            case (state_reg)
                2'b11: begin
                    target[0] = FAST_D;
                    target[1] = FAST_D;
                end
                2'b10: begin
                    target[0] = SLOW_D;
                    target[1] = FAST_D;
                end
                2'b01: begin
                    target[0] = FAST_D;
                    target[1] = SLOW_D;
                end
                default: begin
                    target[0] = '0;
                    target[1] = '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            logic [PWM_BITS-1:0] work_reg;
            logic [PWM_BITS-1:0] work_next;
            logic [PWM_BITS-1:0] applied_reg;
            logic [PWM_BITS-1:0] applied_next;
            logic                pwm_reg;

            always_comb begin
                work_next = work_reg;
                if (target[gi] == '0) begin
                    // Stop is immediate, never ramped.
                    work_next = '0;
                end else if (ramp_tick) begin
                    // Distances are only formed in the non-negative
                    // direction, so neither side can wrap.
                    if (work_reg < target[gi]) begin
                        if ((target[gi] - work_reg) <= STEP_D)
                            work_next = target[gi];
                        else
                            work_next = work_reg + STEP_D;
                    end else if (work_reg > target[gi]) begin
                        if ((work_reg - target[gi]) <= STEP_D)
                            work_next = target[gi];
                        else
                            work_next = work_reg - STEP_D;
                    end
                end

                applied_next = applied_reg;
                if (work_next == '0)
                    applied_next = '0;
                else if (cnt_wrap)
                    applied_next = work_reg;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    work_reg    <= '0;
                    applied_reg <= '0;
                    pwm_reg     <= 1'b0;
                end else begin
                    work_reg    <= work_next;
                    applied_reg <= applied_next;
                    pwm_reg     <= (cnt_reg < applied_reg);
                end
            end

            assign pwm_vec[gi]    = pwm_reg;
            assign applied_nz[gi] = (applied_reg != '0);
        end
    endgenerate

    assign left_pwm  = pwm_vec[0];
    assign right_pwm = pwm_vec[1];
    assign left_in   = applied_nz[0] ? 2'b10 : 2'b00;
    assign right_in  = applied_nz[1] ? 2'b10 : 2'b00;
    assign moving    = moving_reg;

endmodule
